// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - requester/consumer bundle for the 4:1 round-robin mux arbiter
//
// Purpose: groups the four request/data lines and the valid/ready output
// channel shared between the arbiter and its surroundings.
// Signals:
//   req[3:0]      request per requester (bit i = requester i)
//   d0..d3        requester data inputs
//   out_ready     downstream accepts out_data this cycle
//   gnt[3:0]      one-hot registered grant, zero when idle
//   sel[1:0]      registered mux select
//   out_valid     granted requester's data is valid
//   out_data      muxed data
//   busy          arbiter holds an active grant
// Modports: slave = arbiter side, master = requesters/consumer side.
interface mux4_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        req;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic              out_ready;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output gnt, sel, out_valid, out_data, busy
  );

  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  gnt, sel, out_valid, out_data, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin scheduler driving a shared 4:1 data mux
//
// Purpose: grants one of four requesters at a time, with at most MAX_BURST
// transfers per grant, and presents the selected data on a valid/ready channel.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux4_rr_arbiter_if.slave (req, d0..d3, out_ready in;
//          gnt, sel, out_valid, out_data, busy out)
module mux4_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_rr_arbiter_if.slave      bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [1:0]        last_gnt_q, last_gnt_d;

  logic [DATA_W-1:0] mux_data;
  logic              out_valid;
  logic              xfer;
  logic              release_now;
  logic [2:0]        pick_idle;
  logic [2:0]        pick_rel;

  // Returns {found, index}: first set bit of r searching upward from last+1,
  // wrapping; the last-served index is therefore checked last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!res[2] && r[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  always_comb begin
    case (sel_q)
      2'd0:    mux_data = bus.d0;
      2'd1:    mux_data = bus.d1;
      2'd2:    mux_data = bus.d2;
      default: mux_data = bus.d3;
    endcase
  end

  // Only the granted line can raise out_valid; other requests are invisible here.
  assign out_valid     = (state_q == ACTIVE) && bus.req[sel_q];
  assign xfer          = out_valid && bus.out_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mux_data : '0;
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == ACTIVE);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    beat_cnt_d  = beat_cnt_q;
    last_gnt_d  = last_gnt_q;
    release_now = 1'b0;
    pick_idle   = rr_pick(bus.req, last_gnt_q);
    // On release the releasing index becomes the new last_gnt, so search from sel_q.
    pick_rel    = rr_pick(bus.req, sel_q);

    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d    = ACTIVE;
          sel_d      = pick_idle[1:0];
          gnt_d      = 4'b0001 << pick_idle[1:0];
          beat_cnt_d = 4'd0;
        end
      end
      ACTIVE: begin
        release_now = !bus.req[sel_q] || (xfer && ((beat_cnt_q + 4'd1) == BURST_LIM));
        if (release_now) begin
          last_gnt_d = sel_q;
          beat_cnt_d = 4'd0;
          if (pick_rel[2]) begin
            sel_d = pick_rel[1:0];
            gnt_d = 4'b0001 << pick_rel[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'b00;
      beat_cnt_q <= 4'd0;
      last_gnt_q <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if #(.DATA_W(8)) bus ();

  mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp;
  int n_err;
  logic [9:0] exp_q[$];
  logic [7:0] dval[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input int beats);
    logic [1:0] s;
    s = 2'(idx);
    for (int b = 0; b < beats; b++) exp_q.push_back({s, dval[idx]});
  endtask

  // Scoreboard: every accepted beat must match the next expected {sel, data}.
  always @(posedge clk) begin
    logic [9:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", {22'd0, bus.sel, bus.out_data}, 32'h3ff);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_sel_data", {22'd0, bus.sel, bus.out_data}, {22'd0, e});
      end
    end
  end

  initial begin
    logic [1:0] ord[5];
    n_cmp = 0;
    n_err = 0;
    dval[0] = 8'h3C;
    dval[1] = 8'h5A;
    dval[2] = 8'hA5;
    dval[3] = 8'hC3;
    bus.d0 = dval[0];
    bus.d1 = dval[1];
    bus.d2 = dval[2];
    bus.d3 = dval[3];
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;

    // Reset then idle
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_sel", bus.sel, 2'b00);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt", bus.gnt, 4'b0000);
      chk("idle_valid", bus.out_valid, 1'b0);
      chk("idle_busy", bus.busy, 1'b0);
    end

    // Single requester 2: one-cycle grant latency, 4 beats, re-grant with no bubble
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    push_exp(2, 4);
    #1;
    chk("single_latency_gnt", bus.gnt, 4'b0000);
    tick();
    chk("single_gnt", bus.gnt, 4'b0100);
    chk("single_sel", bus.sel, 2'd2);
    chk("single_data", bus.out_data, 8'hA5);
    for (int i = 0; i < 4; i++) tick();
    chk("single_regrant_gnt", bus.gnt, 4'b0100);
    chk("single_regrant_busy", bus.busy, 1'b1);
    chk("single_regrant_valid", bus.out_valid, 1'b1);
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    #1;
    chk("drop_valid", bus.out_valid, 1'b0);
    chk("drop_data", bus.out_data, 8'h00);
    tick();
    chk("single_end_busy", bus.busy, 1'b0);
    chk("single_end_gnt", bus.gnt, 4'b0000);

    // Fair rotation from a fresh reset: 0,1,2,3,0 with 4 beats each
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3; ord[4] = 2'd0;
    for (int g = 0; g < 5; g++) push_exp(int'(ord[g]), 4);
    tick();
    for (int b = 0; b < 20; b++) begin
      chk("rot_sel", bus.sel, ord[b / 4]);
      chk("rot_gnt", bus.gnt, 4'b0001 << ord[b / 4]);
      tick();
    end
    chk("rot_next_sel", bus.sel, 2'd1);
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    chk("rot_end_busy", bus.busy, 1'b0);

    // Backpressure on requester 1: grant holds, first beat when out_ready rises
    bus.req = 4'b0010;
    tick();
    chk("bp_gnt", bus.gnt, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      chk("bp_stall_gnt", bus.gnt, 4'b0010);
      chk("bp_stall_valid", bus.out_valid, 1'b1);
      tick();
    end
    push_exp(1, 4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_q_drained", exp_q.size(), 0);
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    chk("bp_end_busy", bus.busy, 1'b0);

    // Early drop: requester 1 for two beats, then hand off to 3
    bus.req = 4'b0010;
    tick();
    chk("early_gnt1", bus.gnt, 4'b0010);
    push_exp(1, 2);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.req = 4'b1000;
    bus.out_ready = 1'b0;
    #1;
    chk("early_nongranted_valid", bus.out_valid, 1'b0);
    chk("early_nongranted_data", bus.out_data, 8'h00);
    tick();
    chk("early_gnt3", bus.gnt, 4'b1000);
    chk("early_sel3", bus.sel, 2'd3);
    bus.req = 4'b1011;
    bus.out_ready = 1'b1;
    ord[0] = 2'd3; ord[1] = 2'd0; ord[2] = 2'd1;
    for (int g = 0; g < 3; g++) push_exp(int'(ord[g]), 4);
    for (int b = 0; b < 12; b++) begin
      chk("prio_sel", bus.sel, ord[b / 4]);
      tick();
    end
    chk("prio_wrap_sel", bus.sel, 2'd3);

    // Reset mid-burst during requester 3's second beat
    push_exp(3, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", bus.gnt, 4'b0000);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk("post_rst_gnt", bus.gnt, 4'b0001);
    chk("post_rst_sel", bus.sel, 2'd0);
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    chk("final_busy", bus.busy, 1'b0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
